// File: rtl/module_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// module_mem_pkg : shared widths, opcodes and types for the MEM stage
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
package module_mem_pkg;

  localparam int RegBus          = 32;
  localparam int RegAddrBus      = 5;
  localparam int OpCodeBus       = 11;
  localparam int TIMEOUT_DEFAULT = 16;
  localparam int TIMER_W         = 5;

  localparam logic [OpCodeBus-1:0]  OP_LDUR = 11'h7C2;
  localparam logic [OpCodeBus-1:0]  OP_STUR = 11'h7C0;
  // Branch opcodes are prefix-decoded; these are the base encodings.
  localparam logic [OpCodeBus-1:0]  OP_B    = 11'h0A0;  // 6-bit prefix 000101
  localparam logic [OpCodeBus-1:0]  OP_CBZ  = 11'h5A0;  // 8-bit prefix 10110100
  localparam logic [OpCodeBus-1:0]  OP_CBNZ = 11'h5A8;  // 8-bit prefix 10110101
  localparam logic [RegAddrBus-1:0] XZR     = 5'd31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // True for instructions that never write a register (B, CBZ, CBNZ).
  function automatic logic is_branch(input logic [OpCodeBus-1:0] op);
    return (op[10:5] == OP_B[10:5]) ||
           (op[10:3] == OP_CBZ[10:3]) ||
           (op[10:3] == OP_CBNZ[10:3]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/module_mem_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// module_mem_if : data-memory request/response bus
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
interface module_mem_if;
  import module_mem_pkg::*;

  logic              req;
  logic              we;
  logic [RegBus-1:0] addr;
  logic [RegBus-1:0] wdata;
  logic              ack;
  logic [RegBus-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface
`default_nettype wire

// File: rtl/module_mem_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_req_timer : counts WAIT cycles without acknowledge
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module mem_req_timer
  import module_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clear_i,
  input  wire logic enable_i,
  output logic      expired_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  // Clear has priority so a fresh request always starts from zero.
  always_comb begin
    count_d = count_q;
    if (clear_i)       count_d = '0;
    else if (enable_i) count_d = count_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign expired_o = (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/module_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// module_mem : pipeline MEM stage with data-memory handshake and timeout
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module module_mem
  import module_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  mem_valid_i,
  input  wire logic [OpCodeBus-1:0]  mem_opcode_i,
  input  wire logic [RegAddrBus-1:0] mem_waddr_i,
  input  wire logic [RegBus-1:0]     mem_result_i,
  input  wire logic [RegBus-1:0]     mem_reg2_i,
  module_mem_if.master               dm,
  output logic                       mem_stall_o,
  output logic                       wb_valid_o,
  output logic                       wb_wreg_o,
  output logic [RegAddrBus-1:0]      wb_waddr_o,
  output logic [RegBus-1:0]          wb_wdata_o,
  output logic                       mem_fault_o
);

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [RegBus-1:0]       addr_q, addr_d;
  logic [RegBus-1:0]       wdata_q, wdata_d;
  logic [RegAddrBus-1:0]   waddr_q, waddr_d;
  logic                    load_q, load_d;
  logic                    wb_valid_q, wb_valid_d;
  logic                    wb_wreg_q, wb_wreg_d;
  logic [RegAddrBus-1:0]   wb_waddr_q, wb_waddr_d;
  logic [RegBus-1:0]       wb_wdata_q, wb_wdata_d;
  logic                    fault_q, fault_d;

  logic timer_clear, timer_en, timer_expired;
  logic is_load, is_store, aligned;

  assign is_load  = (mem_opcode_i == OP_LDUR);
  assign is_store = (mem_opcode_i == OP_STUR);
  assign aligned  = (mem_result_i[1:0] == 2'b00);

  mem_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .expired_o (timer_expired)
  );

  // Next-state, request and writeback decode; acknowledge beats timeout.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    load_d      = load_q;
    wb_valid_d  = 1'b0;
    wb_wreg_d   = 1'b0;
    wb_waddr_d  = wb_waddr_q;
    wb_wdata_d  = wb_wdata_q;
    fault_d     = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid_i) begin
          if (is_load || is_store) begin
            if (aligned) begin
              state_d     = ST_WAIT;
              req_d       = 1'b1;
              we_d        = is_store;
              addr_d      = mem_result_i;
              wdata_d     = mem_reg2_i;
              waddr_d     = mem_waddr_i;
              load_d      = is_load;
              timer_clear = 1'b1;
            end else begin
              // Misaligned access retires immediately as a fault.
              wb_valid_d = 1'b1;
              fault_d    = 1'b1;
              wb_waddr_d = mem_waddr_i;
              wb_wdata_d = mem_result_i;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_wreg_d  = !is_branch(mem_opcode_i) && (mem_waddr_i != XZR);
            wb_waddr_d = mem_waddr_i;
            wb_wdata_d = mem_result_i;
          end
        end
      end
      ST_WAIT: begin
        if (dm.ack) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          we_d       = 1'b0;
          wb_valid_d = 1'b1;
          wb_waddr_d = waddr_q;
          if (load_q) begin
            wb_wdata_d = dm.rdata;
            wb_wreg_d  = (waddr_q != XZR);
          end
        end else if (timer_expired) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          we_d       = 1'b0;
          wb_valid_d = 1'b1;
          fault_d    = 1'b1;
          wb_waddr_d = waddr_q;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      load_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_wreg_q  <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      load_q     <= load_d;
      wb_valid_q <= wb_valid_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
      fault_q    <= fault_d;
    end
  end

  assign mem_stall_o = (state_q == ST_WAIT);
  assign dm.req      = req_q;
  assign dm.we       = we_q;
  assign dm.addr     = addr_q;
  assign dm.wdata    = wdata_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_wreg_o   = wb_wreg_q;
  assign wb_waddr_o  = wb_waddr_q;
  assign wb_wdata_o  = wb_wdata_q;
  assign mem_fault_o = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_module_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_module_mem : directed self-checking bench for module_mem
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_module_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic [10:0] mem_opcode_i = '0;
  logic [4:0]  mem_waddr_i = '0;
  logic [31:0] mem_result_i = '0;
  logic [31:0] mem_reg2_i = '0;
  logic        mem_stall_o, wb_valid_o, wb_wreg_o, mem_fault_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;

  int errors = 0;
  int checks = 0;

  module_mem_if dm ();

  module_mem #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_valid_i  (mem_valid_i),
    .mem_opcode_i (mem_opcode_i),
    .mem_waddr_i  (mem_waddr_i),
    .mem_result_i (mem_result_i),
    .mem_reg2_i   (mem_reg2_i),
    .dm           (dm.master),
    .mem_stall_o  (mem_stall_o),
    .wb_valid_o   (wb_valid_o),
    .wb_wreg_o    (wb_wreg_o),
    .wb_waddr_o   (wb_waddr_o),
    .wb_wdata_o   (wb_wdata_o),
    .mem_fault_o  (mem_fault_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge, then drop valid.
  task automatic issue(input logic [10:0] op, input logic [31:0] res,
                       input logic [31:0] r2, input logic [4:0] wa);
    mem_valid_i  = 1'b1;
    mem_opcode_i = op;
    mem_result_i = res;
    mem_reg2_i   = r2;
    mem_waddr_i  = wa;
    step();
    mem_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    dm.ack = 1'b0;
    dm.rdata = '0;
    step();
    step();
    checks++; if ({dm.req, dm.we, mem_stall_o} !== 3'b000) begin errors++; $display("FAIL reset_bus: got %b required 000", {dm.req, dm.we, mem_stall_o}); end
    checks++; if ({wb_valid_o, wb_wreg_o, mem_fault_o} !== 3'b000) begin errors++; $display("FAIL reset_wb: got %b required 000", {wb_valid_o, wb_wreg_o, mem_fault_o}); end
    checks++; if ({dm.addr, wb_wdata_o, wb_waddr_o} !== 69'h0) begin errors++; $display("FAIL reset_data: got %h required 0", {dm.addr, wb_wdata_o, wb_waddr_o}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    issue(11'h458, 32'h3, 32'h0, 5'd2);
    checks++; if ({wb_valid_o, wb_wreg_o, mem_fault_o} !== 3'b110) begin errors++; $display("FAIL add_wb: got %b required 110", {wb_valid_o, wb_wreg_o, mem_fault_o}); end
    checks++; if (wb_wdata_o !== 32'h3 || wb_waddr_o !== 5'd2) begin errors++; $display("FAIL add_data: got %h/%0d required 3/2", wb_wdata_o, wb_waddr_o); end
    checks++; if (dm.req !== 1'b0 || mem_stall_o !== 1'b0) begin errors++; $display("FAIL add_noreq: got %b%b required 00", dm.req, mem_stall_o); end
    step();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL add_pulse: got %b required 0", wb_valid_o); end
  endtask

  task automatic test_wreg();
    logic [10:0] ops [4] = '{11'h0A0, 11'h5A3, 11'h5AC, 11'h458};
    logic [4:0]  was [4] = '{5'd1, 5'd4, 5'd9, 5'd31};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 32'h100 + i, 32'h0, was[i]);
      checks++; if ({wb_valid_o, wb_wreg_o} !== 2'b10) begin errors++; $display("FAIL wreg_off[%0d]: got %b required 10", i, {wb_valid_o, wb_wreg_o}); end
    end
  endtask

  task automatic test_ldur();
    issue(11'h7C2, 32'h10, 32'h0, 5'd5);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({mem_stall_o, dm.req, dm.we} !== 3'b110 || dm.addr !== 32'h10) begin errors++; $display("FAIL ldur_wait[%0d]: got %b addr %h required 110 addr 10", i, {mem_stall_o, dm.req, dm.we}, dm.addr); end
      // An instruction offered during WAIT must be ignored.
      mem_valid_i  = (i < 2);
      mem_opcode_i = 11'h458;
      mem_result_i = 32'h999;
      mem_waddr_i  = 5'd7;
      if (i == 2) begin dm.ack = 1'b1; dm.rdata = 32'hDEADBEEF; end
      step();
    end
    dm.ack = 1'b0;
    dm.rdata = 32'h0;
    checks++; if ({wb_valid_o, wb_wreg_o, mem_fault_o, mem_stall_o, dm.req} !== 5'b11000) begin errors++; $display("FAIL ldur_done: got %b required 11000", {wb_valid_o, wb_wreg_o, mem_fault_o, mem_stall_o, dm.req}); end
    checks++; if (wb_wdata_o !== 32'hDEADBEEF || wb_waddr_o !== 5'd5) begin errors++; $display("FAIL ldur_data: got %h/%0d required deadbeef/5", wb_wdata_o, wb_waddr_o); end
    step();
  endtask

  task automatic test_stur_back_to_back();
    issue(11'h7C0, 32'h20, 32'h55, 5'd7);
    checks++; if ({dm.req, dm.we} !== 2'b11 || dm.wdata !== 32'h55 || dm.addr !== 32'h20) begin errors++; $display("FAIL stur_req: got %b %h %h required 11 55 20", {dm.req, dm.we}, dm.wdata, dm.addr); end
    dm.ack = 1'b1;
    mem_valid_i  = 1'b1;
    mem_opcode_i = 11'h458;
    mem_result_i = 32'h77;
    mem_waddr_i  = 5'd3;
    step();
    dm.ack = 1'b0;
    checks++; if ({wb_valid_o, wb_wreg_o, mem_fault_o, dm.req, dm.we} !== 5'b10000) begin errors++; $display("FAIL stur_done: got %b required 10000", {wb_valid_o, wb_wreg_o, mem_fault_o, dm.req, dm.we}); end
    step();
    mem_valid_i = 1'b0;
    checks++; if ({wb_valid_o, wb_wreg_o} !== 2'b11 || wb_wdata_o !== 32'h77) begin errors++; $display("FAIL b2b_next: got %b %h required 11 77", {wb_valid_o, wb_wreg_o}, wb_wdata_o); end
    step();
  endtask

  task automatic test_misaligned();
    issue(11'h7C2, 32'h13, 32'h0, 5'd4);
    checks++; if ({dm.req, mem_stall_o} !== 2'b00) begin errors++; $display("FAIL mis_noreq: got %b required 00", {dm.req, mem_stall_o}); end
    checks++; if ({wb_valid_o, wb_wreg_o, mem_fault_o} !== 3'b101) begin errors++; $display("FAIL mis_fault: got %b required 101", {wb_valid_o, wb_wreg_o, mem_fault_o}); end
    step();
    checks++; if ({wb_valid_o, mem_fault_o} !== 2'b00) begin errors++; $display("FAIL mis_pulse: got %b required 00", {wb_valid_o, mem_fault_o}); end
  endtask

  task automatic test_idle_ack();
    dm.ack = 1'b1;
    dm.rdata = 32'h1234;
    step();
    dm.ack = 1'b0;
    checks++; if ({wb_valid_o, dm.req, mem_stall_o, mem_fault_o} !== 4'b0000) begin errors++; $display("FAIL idle_ack: got %b required 0000", {wb_valid_o, dm.req, mem_stall_o, mem_fault_o}); end
  endtask

  task automatic test_timeout();
    issue(11'h7C2, 32'h40, 32'h0, 5'd6);
    for (int i = 0; i < 16; i++) begin
      checks++; if ({dm.req, mem_stall_o, wb_valid_o} !== 3'b110) begin errors++; $display("FAIL to_hold[%0d]: got %b required 110", i, {dm.req, mem_stall_o, wb_valid_o}); end
      step();
    end
    checks++; if ({dm.req, mem_stall_o, wb_valid_o, wb_wreg_o, mem_fault_o} !== 5'b00101) begin errors++; $display("FAIL to_fault: got %b required 00101", {dm.req, mem_stall_o, wb_valid_o, wb_wreg_o, mem_fault_o}); end
    step();
    checks++; if ({wb_valid_o, mem_fault_o} !== 2'b00) begin errors++; $display("FAIL to_pulse: got %b required 00", {wb_valid_o, mem_fault_o}); end
  endtask

  task automatic test_ack_at_timeout();
    issue(11'h7C2, 32'h44, 32'h0, 5'd8);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin dm.ack = 1'b1; dm.rdata = 32'hCAFE0001; end
      step();
    end
    dm.ack = 1'b0;
    checks++; if ({wb_valid_o, wb_wreg_o, mem_fault_o, dm.req} !== 4'b1100) begin errors++; $display("FAIL ackto_done: got %b required 1100", {wb_valid_o, wb_wreg_o, mem_fault_o, dm.req}); end
    checks++; if (wb_wdata_o !== 32'hCAFE0001 || wb_waddr_o !== 5'd8) begin errors++; $display("FAIL ackto_data: got %h/%0d required cafe0001/8", wb_wdata_o, wb_waddr_o); end
    step();
  endtask

  task automatic test_reset_in_wait();
    issue(11'h7C2, 32'h50, 32'h0, 5'd9);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({dm.req, mem_stall_o, wb_valid_o} !== 3'b000) begin errors++; $display("FAIL rstwait_now: got %b required 000", {dm.req, mem_stall_o, wb_valid_o}); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({wb_valid_o, dm.req, mem_fault_o} !== 3'b000) begin errors++; $display("FAIL rstwait_after[%0d]: got %b required 000", i, {wb_valid_o, dm.req, mem_fault_o}); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_wreg();
    test_ldur();
    test_stur_back_to_back();
    test_misaligned();
    test_idle_ack();
    test_timeout();
    test_ack_at_timeout();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/module_mem.md
MODULE_MEM -- requirements
Module: module_mem

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the number of WAIT cycles without dm_ack_i before a bus fault.
REQ-002 clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 mem_valid_i  in  1  SHALL mark a valid instruction from EX.
REQ-005 mem_opcode_i  in  11  SHALL carry the instruction opcode.
REQ-006 mem_waddr_i  in  5  SHALL carry the destination register.
REQ-007 mem_result_i  in  32  SHALL carry the ALU result, used as the memory address for loads and stores.
REQ-008 mem_reg2_i  in  32  SHALL carry the store data.
REQ-009 dm_req_o, dm_we_o  out  1 each  SHALL carry the data-memory request and the write strobe.
REQ-010 dm_addr_o, dm_wdata_o  out  32 each  SHALL carry the data-memory address and write data.
REQ-011 dm_ack_i  in  1, dm_rdata_i  in  32  SHALL carry the memory completion and the read data.
REQ-012 mem_stall_o  out  1  SHALL freeze EX and upstream stages.
REQ-013 wb_valid_o, wb_wreg_o  out  1 each  SHALL carry the retire pulse and the register-write enable.
REQ-014 wb_waddr_o  out  5, wb_wdata_o  out  32  SHALL carry the writeback destination and data.
REQ-015 mem_fault_o  out  1  SHALL pulse for one cycle on a misaligned access or a timeout.

Function
REQ-016 FSM states SHALL be IDLE and WAIT; mem_stall_o SHALL equal (state==WAIT), decoded from the registered state only.
REQ-017 The block SHALL accept an instruction at a rising edge when state==IDLE and mem_valid_i=1; it SHALL ignore mem_valid_i in WAIT.
REQ-018 Non-memory op: wb_* SHALL be registered, valid the cycle after acceptance (latency 1), with wb_wdata_o=mem_result_i.
REQ-019 For a non-memory op, wb_wreg_o SHALL be 1 unless the opcode is B, CBZ or CBNZ, or waddr==31 (XZR).
REQ-020 LDUR/STUR with mem_result_i[1:0]==0: next state WAIT; dm_req_o=1, dm_we_o=(STUR), addr/wdata/waddr latched and held constant through WAIT.
REQ-021 Misaligned LDUR/STUR: no request issued; next cycle wb_valid_o=1, wb_wreg_o=0, mem_fault_o=1.
REQ-022 In WAIT with dm_ack_i=1: dm_req_o SHALL drop at that edge, state SHALL go to IDLE, and wb_valid_o=1 in the following cycle.
REQ-023 On LDUR completion, wb_wdata_o SHALL equal the dm_rdata_i sampled with ack, and wb_wreg_o=(waddr!=31).
REQ-024 On STUR completion, wb_wreg_o SHALL be 0.
REQ-025 A 5-bit counter SHALL clear on entering WAIT and increment each WAIT cycle without ack.
REQ-026 When the counter reaches TIMEOUT-1 without ack, the block SHALL go to IDLE, drop dm_req_o, and pulse wb_valid_o=1, wb_wreg_o=0, mem_fault_o=1.
REQ-027 If ack coincides with the timeout cycle, ack SHALL win: normal completion, no fault.
REQ-028 dm_ack_i while IDLE SHALL be ignored.
REQ-029 wb_valid_o and mem_fault_o SHALL be single-cycle pulses.
REQ-030 No new instruction SHALL be accepted in the ack/timeout cycle; the earliest next acceptance is the following edge (back-to-back memory ops: one idle cycle).

Reset
REQ-031 Reset assertion SHALL immediately force state=IDLE, counter=0, and all outputs to 0, including dm_req_o mid-WAIT; the in-flight access is discarded with no writeback.
REQ-032 Reset deassertion SHALL be synchronised by the instantiating level; the block SHALL accept its first instruction no earlier than the first edge after deassertion.

Structure
REQ-033 Opcodes (LDUR 11'h7C2, STUR 11'h7C0, B, CBZ, CBNZ) and the widths RegBus, RegAddrBus, OpCodeBus SHALL live in the shared defines package; TIMEOUT default likewise.
REQ-034 The timeout counter SHALL be one sub-module, mem_req_timer (clear, enable, expired).

Verification
REQ-035 ADD: opcode 11'h458, result 32'h3, waddr 2 -> next cycle wb_valid_o=1, wb_wreg_o=1, wb_wdata_o=32'h3, no dm_req_o.
REQ-036 LDUR: addr 32'h10, waddr 5, ack after 3 cycles with rdata 32'hDEADBEEF -> stall high for 3 cycles, then wb_wdata_o=32'hDEADBEEF, wb_wreg_o=1.
REQ-037 STUR: addr 32'h20, reg2 32'h55, immediate ack -> dm_we_o=1, dm_wdata_o=32'h55; wb_valid_o=1, wb_wreg_o=0.
REQ-038 Misaligned LDUR at 32'h13 -> no dm_req_o; mem_fault_o pulses; wb_wreg_o=0.
REQ-039 LDUR never acked -> dm_req_o held 16 cycles, then fault pulse; then a second LDUR acked at cycle 15 (ack coincides with timeout) -> normal completion, no fault.
REQ-040 Reset asserted in WAIT cycle 2 -> dm_req_o, mem_stall_o low immediately; no wb_valid_o after release.
